seq_approx_mult: RTL and testbench

- Parametrised, iterative shift-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Per-operation mode select between an exact product and a truncated, broken-array approximate product. In approximate mode, partial-product bits in columns below TRUNC are dropped.
- Sits in the approximate-arithmetic datapath behind a valid/ready handshake on input and output.
- The exact a*b result is the golden comparison for error measurement.

---
 rtl/mult_pkg.sv | 36 +++
 rtl/seq_approx_mult.sv | 125 ++++++++++++
 tb/tb_seq_approx_mult.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential approximate multiplier.
//   state_t    : control states of the shift-add FSM
//   MAX_WIDTH  : widest operand the block is meant to be built with
//   approx_ref : behavioural product with the low 'trunc' columns dropped
//                from every partial product (trunc=0 gives the exact product)
package mult_pkg;

    localparam int MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic logic [2*MAX_WIDTH-1:0] approx_ref(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input int                   trunc
    );
        logic [2*MAX_WIDTH-1:0] sum;
        logic [2*MAX_WIDTH-1:0] keep;
        logic [2*MAX_WIDTH-1:0] pp;
        sum  = '0;
        keep = '1;
        keep = keep << trunc;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (b[i]) begin
                pp  = {{MAX_WIDTH{1'b0}}, a} << i;
                sum = sum + (pp & keep);
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/seq_approx_mult.sv
// Iterative shift-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH, one
// partial product per cycle. In approximate mode each partial product has
// its low TRUNC columns cleared before accumulation.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b, approx)
//   a, b                  unsigned operands
//   approx                1 = truncated product, 0 = exact product
//   out_valid / out_ready result handshake
//   y                     product, held after handoff until overwritten
//   y_approx              mode y was computed in
module seq_approx_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int TRUNC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y,
    output logic               y_approx
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             approx_q;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    term;
    logic [CW-1:0]    cnt;
    logic             last_iter;

    // Column mask applied to every partial product.
    function automatic logic [PW-1:0] pp_mask(input logic approx_sel);
        logic [PW-1:0] m;
        m = '1;
        if (approx_sel) begin
            m = m << TRUNC;
        end
        return m;
    endfunction

    always_comb begin
        pp        = {{WIDTH{1'b0}}, a_q} << cnt;
        term      = b_q[cnt] ? (pp & pp_mask(approx_q)) : '0;
        last_iter = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC;
            end
            CALC: begin
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Fixed WIDTH iterations regardless of operand values; the final
    // iteration writes acc+term straight into y so out_valid rises exactly
    // WIDTH cycles after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            approx_q <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            y        <= '0;
            y_approx <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        approx_q <= approx;
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                CALC: begin
                    acc <= acc + term;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        y        <= acc + term;
                        y_approx <= approx_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_approx_mult.sv
module tb_seq_approx_mult;
    import mult_pkg::*;

    localparam int T4 = 2;
    localparam int T8 = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       iv4 = 1'b0, rdy4, ap4 = 1'b0, ov4, or4 = 1'b0, ya4;
    logic [3:0] a4 = '0, b4 = '0;
    logic [7:0] y4;

    logic        iv8 = 1'b0, rdy8, ap8 = 1'b0, ov8, or8 = 1'b0, ya8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] y8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_approx_mult #(.WIDTH(4), .TRUNC(T4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4), .a(a4), .b(b4),
        .approx(ap4), .out_valid(ov4), .out_ready(or4), .y(y4), .y_approx(ya4)
    );

    seq_approx_mult #(.WIDTH(8), .TRUNC(T8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .a(a8), .b(b8),
        .approx(ap8), .out_valid(ov8), .out_ready(or8), .y(y8), .y_approx(ya8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ap;
        logic [7:0] y;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation on the 4-bit instance and collect the result.
    task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic ap,
                          input int hold, output logic [7:0] y, output logic ya,
                          output int lat);
        int guard;
        guard = 0;
        while (!rdy4 && guard < 100) begin tick; guard++; end
        if (!rdy4) chk("w4_ready_timeout", 0, 1);
        a4 = a; b4 = b; ap4 = ap; iv4 = 1'b1; or4 = 1'b0;
        tick;
        iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); ap4 = ~ap;
        lat = 0;
        while (!ov4 && lat < 100) begin tick; lat++; end
        y = y4; ya = ya4;
        repeat (hold) tick;
        or4 = 1'b1;
        tick;
        or4 = 1'b0;
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic ap,
                          input int hold, output logic [15:0] y, output logic ya,
                          output int lat);
        int guard;
        guard = 0;
        while (!rdy8 && guard < 100) begin tick; guard++; end
        if (!rdy8) chk("w8_ready_timeout", 0, 1);
        a8 = a; b8 = b; ap8 = ap; iv8 = 1'b1; or8 = 1'b0;
        tick;
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); ap8 = ~ap;
        lat = 0;
        while (!ov8 && lat < 100) begin tick; lat++; end
        y = y8; ya = ya8;
        repeat (hold) tick;
        or8 = 1'b1;
        tick;
        or8 = 1'b0;
    endtask

    initial begin
        vec_t        vecs[8];
        logic [7:0]  ry4;
        logic [15:0] ry8;
        logic        rya;
        int          lat;
        int          guard;
        logic [31:0] exp;
        int          err_cases4;
        int          err_cases8;
        int          approx_ops4;
        int          approx_ops8;

        vecs[0] = '{4'd3,  4'd3,  1'b0, 8'd9};
        vecs[1] = '{4'd3,  4'd3,  1'b1, 8'd4};
        vecs[2] = '{4'd15, 4'd15, 1'b1, 8'd220};
        vecs[3] = '{4'd0,  4'd15, 1'b0, 8'd0};
        vecs[4] = '{4'd0,  4'd15, 1'b1, 8'd0};
        vecs[5] = '{4'd15, 4'd15, 1'b0, 8'd225};
        vecs[6] = '{4'd5,  4'd6,  1'b1, 8'd28};
        vecs[7] = '{4'd9,  4'd1,  1'b1, 8'd8};

        // Reset state
        repeat (2) tick;
        chk("rst_in_ready", 32'(rdy4), 1);
        chk("rst_out_valid", 32'(ov4), 0);
        chk("rst_y", 32'(y4), 0);
        chk("rst_y_approx", 32'(ya4), 0);
        rst = 1'b0;
        tick;

        // Directed table
        foreach (vecs[k]) begin
            do_op4(vecs[k].a, vecs[k].b, vecs[k].ap, 0, ry4, rya, lat);
            chk($sformatf("tbl%0d_y", k), 32'(ry4), 32'(vecs[k].y));
            chk($sformatf("tbl%0d_y_approx", k), 32'(rya), 32'(vecs[k].ap));
            chk($sformatf("tbl%0d_latency", k), lat, 4);
            chk($sformatf("tbl%0d_idle_out_valid", k), 32'(ov4), 0);
            chk($sformatf("tbl%0d_idle_in_ready", k), 32'(rdy4), 1);
        end

        // Backpressure: result held, in_valid pulses ignored
        a4 = 4'd15; b4 = 4'd15; ap4 = 1'b0; iv4 = 1'b1; or4 = 1'b0;
        tick;
        iv4 = 1'b0;
        guard = 0;
        while (!ov4 && guard < 100) begin tick; guard++; end
        for (int c = 0; c < 10; c++) begin
            iv4 = c[0]; a4 = 4'd1; b4 = 4'd1; ap4 = 1'b1;
            tick;
            chk("bp_out_valid", 32'(ov4), 1);
            chk("bp_y", 32'(y4), 225);
            chk("bp_in_ready", 32'(rdy4), 0);
        end
        iv4 = 1'b0; or4 = 1'b1;
        tick;
        or4 = 1'b0;
        chk("bp_release_out_valid", 32'(ov4), 0);
        chk("bp_release_in_ready", 32'(rdy4), 1);
        chk("bp_y_retained", 32'(y4), 225);
        tick;
        chk("bp_no_stale_accept", 32'(rdy4), 1);

        // Reset two cycles into CALC
        a4 = 4'd15; b4 = 4'd15; ap4 = 1'b0; iv4 = 1'b1;
        tick;
        iv4 = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(ov4), 0);
        chk("midrst_y", 32'(y4), 0);
        chk("midrst_in_ready", 32'(rdy4), 1);
        tick;
        rst = 1'b0;
        repeat (6) tick;
        chk("midrst_no_output", 32'(ov4), 0);
        do_op4(4'd5, 4'd6, 1'b0, 0, ry4, rya, lat);
        chk("midrst_next_y", 32'(ry4), 30);
        chk("midrst_next_latency", lat, 4);

        // Random soak, WIDTH=4
        err_cases4 = 0; approx_ops4 = 0;
        for (int n = 0; n < 1000; n++) begin
            logic [3:0] ra, rb;
            logic       rap;
            ra = 4'($urandom); rb = 4'($urandom); rap = 1'($urandom);
            do_op4(ra, rb, rap, $urandom_range(0, 3), ry4, rya, lat);
            exp = rap ? approx_ref(16'(ra), 16'(rb), T4) : 32'(ra) * 32'(rb);
            chk("soak4_y", 32'(ry4), exp);
            chk("soak4_y_approx", 32'(rya), 32'(rap));
            chk("soak4_latency", lat, 4);
            if (rap) begin
                approx_ops4++;
                if (32'(ry4) != 32'(ra) * 32'(rb)) err_cases4++;
            end
        end

        // Random soak, WIDTH=8
        err_cases8 = 0; approx_ops8 = 0;
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra, rb;
            logic       rap;
            ra = 8'($urandom); rb = 8'($urandom); rap = 1'($urandom);
            do_op8(ra, rb, rap, $urandom_range(0, 3), ry8, rya, lat);
            exp = rap ? approx_ref(16'(ra), 16'(rb), T8) : 32'(ra) * 32'(rb);
            chk("soak8_y", 32'(ry8), exp);
            chk("soak8_y_approx", 32'(rya), 32'(rap));
            chk("soak8_latency", lat, 8);
            if (rap) begin
                approx_ops8++;
                chk("soak8_below_exact", 32'(32'(ry8) <= 32'(ra) * 32'(rb)), 1);
                if (32'(ry8) != 32'(ra) * 32'(rb)) err_cases8++;
            end
        end

        $display("approx error cases: W4 %0d of %0d, W8 %0d of %0d",
                 err_cases4, approx_ops4, err_cases8, approx_ops8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
